// File: rtl/l2_cache_wb_pkg.sv
// ----------------------------------------------------------------------------
// l2_cache_wb_pkg
// Shared types and constants for the write-back L2 cache.
//   rv32i_word     : 32-bit CPU word / byte address
//   l2_state_e     : cache controller states
//   line_bytes()   : bytes per line for a given offset width
//   LINE_BYTES,
//   LINE_BITS,
//   BE_BITS        : line and byte-enable widths for the default geometry
// ----------------------------------------------------------------------------
package l2_cache_wb_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOOKUP    = 2'd1,
        S_WRITEBACK = 2'd2,
        S_FILL      = 2'd3
    } l2_state_e;

    function automatic int line_bytes(input int offset_bits);
        return 1 << offset_bits;
    endfunction

    localparam int LINE_BYTES = line_bytes(5);
    localparam int LINE_BITS  = 8 * LINE_BYTES;
    localparam int BE_BITS    = LINE_BYTES;

endpackage

// File: rtl/l2_lru_ages.sv
// ----------------------------------------------------------------------------
// l2_lru_ages
// Per-set age bookkeeping for true LRU replacement. Ages in a set are always
// a permutation of 0..ASSOCIATIVITY-1; the oldest way is the victim.
//   clk, rst   : clock, synchronous active-high reset (ages = way index)
//   index      : set being accessed / queried
//   access_way : way touched this cycle
//   access_en  : apply the access (touched way becomes age 0)
//   victim_way : way with the largest age in the indexed set
// ----------------------------------------------------------------------------
module l2_lru_ages #(
    parameter int ASSOCIATIVITY = 4,
    parameter int s_index       = 3,
    localparam int W            = $clog2(ASSOCIATIVITY)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_index-1:0] index,
    input  logic [W-1:0]       access_way,
    input  logic               access_en,
    output logic [W-1:0]       victim_way
);

    localparam int SETS = 2 ** s_index;

    logic [W-1:0] age_q [ASSOCIATIVITY][SETS];

    // Touched way drops to 0; only ways younger than it age by one, which
    // keeps the set a permutation without any renormalisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    age_q[w][s] <= W'(w);
                end
            end
        end else if (access_en) begin
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                if (W'(w) == access_way) begin
                    age_q[w][index] <= '0;
                end else if (age_q[w][index] < age_q[access_way][index]) begin
                    age_q[w][index] <= age_q[w][index] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (age_q[w][index] == W'(ASSOCIATIVITY - 1)) begin
                victim_way = W'(w);
            end
        end
    end

endmodule

// File: rtl/l2_cache_wb.sv
// ----------------------------------------------------------------------------
// l2_cache_wb
// Set-associative write-back, write-allocate L2 cache with LRU replacement.
//   clk, rst            : clock, synchronous active-high reset
//   mem_*               : CPU side; line-wide read/write, held until mem_resp
//   pmem_*              : memory side; line-wide read/write, held until
//                         pmem_resp
//   hit_count,
//   miss_count          : saturating performance counters
// Hit latency is two cycles (IDLE latch, LOOKUP respond). A miss optionally
// writes back a dirty victim, fills the line, and re-enters LOOKUP, where the
// request completes as a hit that is not counted again.
// ----------------------------------------------------------------------------
module l2_cache_wb
    import l2_cache_wb_pkg::*;
#(
    parameter int ASSOCIATIVITY = 4,
    parameter int s_offset      = 5,
    parameter int s_index       = 3,
    parameter int s_tag         = 32 - s_offset - s_index
) (
    input  logic                          clk,
    input  logic                          rst,
    input  rv32i_word                     mem_address,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [8*(2**s_offset)-1:0]    mem_wdata256,
    input  logic [(2**s_offset)-1:0]      mem_byte_enable256,
    output logic [8*(2**s_offset)-1:0]    mem_rdata256,
    output logic                          mem_resp,
    output rv32i_word                     pmem_address,
    output logic                          pmem_read,
    output logic                          pmem_write,
    output logic [8*(2**s_offset)-1:0]    pmem_wdata,
    input  logic [8*(2**s_offset)-1:0]    pmem_rdata,
    input  logic                          pmem_resp,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);

    localparam int LB   = line_bytes(s_offset);
    localparam int LW   = 8 * LB;
    localparam int SETS = 2 ** s_index;
    localparam int W    = $clog2(ASSOCIATIVITY);

    l2_state_e state_q, state_d;

    // Latched request: the CPU inputs may change while the miss is serviced.
    logic [31-s_offset:0] addr_q;
    logic [LW-1:0]        wdata_q;
    logic [LB-1:0]        be_q;
    logic                 write_q;

    logic [s_tag-1:0] tag_q   [ASSOCIATIVITY][SETS];
    logic [LW-1:0]    data_q  [ASSOCIATIVITY][SETS];
    logic             valid_q [ASSOCIATIVITY][SETS];
    logic             dirty_q [ASSOCIATIVITY][SETS];

    logic [W-1:0] victim_q;
    logic         refill_q;     // current LOOKUP follows a fill: do not count
    logic         pmem_read_q, pmem_write_q;
    logic [31:0]  hit_count_q, hit_count_d;
    logic [31:0]  miss_count_q, miss_count_d;

    logic [s_index-1:0] idx;
    logic [s_tag-1:0]   req_tag;
    logic               hit;
    logic [W-1:0]       hit_way;
    logic [W-1:0]       lru_victim;
    logic [W-1:0]       pick;
    logic               pick_found;
    logic               lru_en;
    logic [LW-1:0]      merged;

    logic unused_offset_bits;
    assign unused_offset_bits = ^mem_address[s_offset-1:0];

    assign idx     = addr_q[s_index-1:0];
    assign req_tag = addr_q[s_index +: s_tag];

    l2_lru_ages #(
        .ASSOCIATIVITY(ASSOCIATIVITY),
        .s_index      (s_index)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .index     (idx),
        .access_way(hit_way),
        .access_en (lru_en),
        .victim_way(lru_victim)
    );

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a value unassigned (which would infer a latch).
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        pick       = lru_victim;
        pick_found = 1'b0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (valid_q[w][idx] && tag_q[w][idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = W'(w);
            end
            if (!pick_found && !valid_q[w][idx]) begin
                pick       = W'(w);
                pick_found = 1'b1;
            end
        end
        for (int b = 0; b < LB; b++) begin
            merged[b*8 +: 8] = be_q[b] ? wdata_q[b*8 +: 8]
                                       : data_q[hit_way][idx][b*8 +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        lru_en       = 1'b0;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    lru_en   = 1'b1;
                    state_d  = S_IDLE;
                    if (!refill_q && hit_count_q != '1)
                        hit_count_d = hit_count_q + 32'd1;
                end else begin
                    if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
                    state_d = (valid_q[pick][idx] && dirty_q[pick][idx])
                              ? S_WRITEBACK : S_FILL;
                end
            end
            S_WRITEBACK: if (pmem_resp) state_d = S_FILL;
            S_FILL:      if (pmem_resp) state_d = S_LOOKUP;
            default:     state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            victim_q     <= '0;
            refill_q     <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            state_q      <= state_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            unique case (state_q)
                S_IDLE: refill_q <= 1'b0;
                S_LOOKUP: begin
                    if (hit) begin
                        if (write_q) dirty_q[hit_way][idx] <= 1'b1;
                    end else begin
                        victim_q <= pick;
                        if (valid_q[pick][idx] && dirty_q[pick][idx])
                            pmem_write_q <= 1'b1;
                        else
                            pmem_read_q <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        pmem_write_q            <= 1'b0;
                        pmem_read_q             <= 1'b1;
                        dirty_q[victim_q][idx]  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (pmem_resp) begin
                        pmem_read_q             <= 1'b0;
                        valid_q[victim_q][idx]  <= 1'b1;
                        dirty_q[victim_q][idx]  <= 1'b0;
                        refill_q                <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag/data storage and the request latch carry no reset; valid
    // bits guard the arrays, and the latch is always written before use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_IDLE && (mem_read || mem_write)) begin
                addr_q  <= mem_address[31:s_offset];
                wdata_q <= mem_wdata256;
                be_q    <= mem_byte_enable256;
                write_q <= mem_write;
            end
            if (state_q == S_LOOKUP && hit && write_q)
                data_q[hit_way][idx] <= merged;
            if (state_q == S_FILL && pmem_resp) begin
                data_q[victim_q][idx] <= pmem_rdata;
                tag_q[victim_q][idx]  <= req_tag;
            end
        end
    end

    assign mem_rdata256 = data_q[hit_way][idx];
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_wdata   = data_q[victim_q][idx];
    assign pmem_address = (state_q == S_WRITEBACK)
                          ? {tag_q[victim_q][idx], idx, {s_offset{1'b0}}}
                          : {req_tag, idx, {s_offset{1'b0}}};
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: doc/l2_cache_wb.md
L2_CACHE_WB -- requirements
Module: l2_cache_wb

Interface
REQ-001 Parameter ASSOCIATIVITY, default 4, number of ways; power of two, at least 2.
REQ-002 Parameter s_offset, default 5, line offset bits; line is 2**s_offset bytes.
REQ-003 Parameter s_index, default 3, index bits; 2**s_index sets.
REQ-004 Parameter s_tag, default 32-s_offset-s_index, tag bits, derived.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 mem_address  in  32  CPU-side byte address; offset bits ignored.
REQ-008 mem_read  in  1  line read request, held until mem_resp.
REQ-009 mem_write  in  1  line write request, held until mem_resp; never asserted together with mem_read.
REQ-010 mem_wdata256  in  8*2**s_offset  write data.
REQ-011 mem_byte_enable256  in  2**s_offset  per-byte write enable.
REQ-012 mem_rdata256  out  8*2**s_offset  read data, valid while mem_resp is high.
REQ-013 mem_resp  out  1  one-cycle completion pulse.
REQ-014 pmem_address  out  32  line-aligned memory address; low s_offset bits are zero.
REQ-015 pmem_read / pmem_write  out  1 each  memory requests, held until pmem_resp.
REQ-016 pmem_wdata  out  8*2**s_offset  victim line.
REQ-017 pmem_rdata  in  8*2**s_offset  fill line, valid with pmem_resp.
REQ-018 pmem_resp  in  1  memory completion pulse.
REQ-019 hit_count, miss_count  out  32 each  saturating performance counters.

Function
REQ-020 The FSM has four states: IDLE, LOOKUP, WRITEBACK and FILL.
REQ-021 IDLE: on mem_read|mem_write, latch the address and data, read the tag/data/valid/dirty arrays, and go to LOOKUP; otherwise remain in IDLE.
REQ-022 LOOKUP on a hit (valid & tag match, at most one way):
- assert mem_resp for exactly one cycle;
- on a read, drive mem_rdata256 from the hit way;
- on a write, merge only the enabled bytes and set that way's dirty bit;
- make the hit way MRU;
- increment hit_count unless it is 0xFFFFFFFF;
- return to IDLE.
REQ-023 Hit latency: mem_resp is high in the second cycle after the request is first seen in IDLE.
REQ-024 LOOKUP on a miss: increment miss_count (saturating); select the victim; go to WRITEBACK if the victim is valid and dirty, else go to FILL.
REQ-025 Victim selection: the lowest-index invalid way; otherwise the way with the largest age.
REQ-026 WRITEBACK: drive pmem_write=1 with pmem_address={victim tag, index, zeros} and pmem_wdata=victim line; on pmem_resp, clear the victim's dirty bit and go to FILL.
REQ-027 FILL: drive pmem_read=1 with pmem_address={request tag, index, zeros}; on pmem_resp, write pmem_rdata, the tag and valid=1, dirty=0 into the victim, then go to LOOKUP. The re-lookup hits and completes the request; the miss counter is not incremented again.
REQ-028 pmem_read and pmem_write are never high together.
REQ-029 Both pmem requests are registered; they deassert in the cycle after pmem_resp.
REQ-030 Ages are per set, each W=log2(ASSOCIATIVITY) bits. On an access to way k, age[k]=0 and every way with age < old age[k] increments. Ages within a set always form a permutation of 0..ASSOCIATIVITY-1.
REQ-031 mem_byte_enable256=0 on a write still completes, updates LRU and sets dirty.
REQ-032 Requests changing between IDLE and mem_resp are ignored; the latched copy is used.

Reset
REQ-033 rst=1 forces, on the next edge:
- state IDLE;
- all valid and dirty bits 0;
- ages per set = way index;
- both counters 0;
- mem_resp, pmem_read and pmem_write 0.
REQ-034 Reset mid-WRITEBACK or mid-FILL abandons the transaction. pmem_read/pmem_write drop on the next edge, and a late pmem_resp seen in IDLE is ignored.
REQ-035 Tag and data arrays are not reset.

Structure
REQ-036 The state enum and the line and byte-enable width constants reside in a shared package alongside rv32i_types.
REQ-037 Age bookkeeping is one sub-module, l2_lru_ages, with ports clk, rst, index, access_way, access_en and victim_way.
REQ-038 Total RTL is 120-400 lines; arrays are inferred registers indexed [way][set].

Verification
REQ-039 Cold read at address 0x00000040: FILL from 0x40 with no WRITEBACK; mem_resp returns pmem_rdata; miss_count=1, hit_count=0.
REQ-040 Repeat read of 0x40: mem_resp in the 2nd cycle with no pmem activity; hit_count=1.
REQ-041 Write 0x40 with byte-enable 0x0000000F and data 0xAA..: bytes 0-3 become AA and the rest are unchanged. Then 4 misses to the same set (stride 0x100) force eviction of 0x40: pmem_write at 0x40 carries the merged line before a pmem_read of the new tag.
REQ-042 LRU check: fill 4 ways of set 0, touch ways 0, 2, 3, then miss. The victim is way 1, and pmem_address shows way 1's tag.
REQ-043 Assert rst during FILL: pmem_read drops on the next edge, and the following read of the same address misses again.
REQ-044 Drive 2**32+5 hits: hit_count holds 0xFFFFFFFF.
